hazard_ctrl: RTL and testbench

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/hazard_pkg.sv | 24 ++
 rtl/hazard_sb.sv | 38 +++
 rtl/hazard_ctrl.sv | 145 ++++++++++++++
 tb/tb_hazard_ctrl.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared definitions for the hazard controller: FSM encoding, parameter sanity
// check and the saturating-increment helper used by the performance counters.
package hazard_pkg;

    localparam logic [0:0] StRun   = 1'b0;
    localparam logic [0:0] StFlush = 1'b1;

    // Flush down-counter width, wide enough for FLUSH_CYC up to 4.
    localparam int unsigned FcW = 3;

    function automatic bit params_ok(int unsigned reg_aw, int unsigned load_lat,
                                     int unsigned flush_cyc, int unsigned cnt_w);
        return (reg_aw >= 1) && (load_lat >= 1) && (load_lat <= 4) &&
               (flush_cyc >= 1) && (flush_cyc <= 4) && (cnt_w >= 1) && (cnt_w <= 32);
    endfunction

    // Counters are at most 32 bits wide; callers widen to 32 and truncate back.
    function automatic logic [31:0] sat_inc(logic [31:0] val, int unsigned width);
        logic [31:0] max_val;
        max_val = (width >= 32) ? 32'hffff_ffff : ((32'd1 << width) - 32'd1);
        return (val >= max_val) ? max_val : val + 32'd1;
    endfunction

endpackage

// File: rtl/hazard_sb.sv
// Load scoreboard: a shift register of {valid, rd} tracking loads that have left
// EX but whose data is not yet forwardable.
module hazard_sb
    import hazard_pkg::*;
#(
    parameter int unsigned REG_AW   = 4,
    parameter int unsigned LOAD_LAT = 2,
    localparam int unsigned Depth   = (LOAD_LAT > 1) ? LOAD_LAT - 1 : 1
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             en_i,
    input  logic                             in_valid_i,
    input  logic [REG_AW-1:0]                in_rd_i,
    output logic [Depth-1:0]                 valid_o,
    output logic [Depth-1:0][REG_AW-1:0]     rd_o
);

    logic [Depth-1:0]             valid_q;
    logic [Depth-1:0][REG_AW-1:0] rd_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
        end else if (en_i) begin
            valid_q[0] <= in_valid_i;
            rd_q[0]    <= in_rd_i;
            for (int k = 1; k < int'(Depth); k++) begin
                valid_q[k] <= valid_q[k-1];
                rd_q[k]    <= rd_q[k-1];
            end
        end
    end

    assign valid_o = valid_q;
    assign rd_o    = rd_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stall detection, branch/JR resolution,
// multi-cycle flush sequencing and saturating stall/mispredict counters.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int unsigned REG_AW    = 4,
    parameter int unsigned LOAD_LAT  = 2,
    parameter int unsigned FLUSH_CYC = 2,
    parameter int unsigned CNT_W     = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid_i,
    input  logic [REG_AW-1:0] id_rs1_i,
    input  logic              id_rs1_used_i,
    input  logic [REG_AW-1:0] id_rs2_i,
    input  logic              id_rs2_used_i,
    input  logic              id_branch_i,
    input  logic              id_taken_i,
    input  logic              id_pred_i,
    input  logic              id_isjump_i,
    input  logic              ex_valid_i,
    input  logic              ex_memread_i,
    input  logic              ex_memtoreg_i,
    input  logic [REG_AW-1:0] ex_rd_i,
    input  logic              mem_wait_i,
    output logic              stall_o,
    output logic              prewrong_o,
    output logic              precorrc_o,
    output logic              jr_o,
    output logic              flush_o,
    output logic [CNT_W-1:0]  stall_cnt_o,
    output logic [CNT_W-1:0]  miss_cnt_o
);

    localparam int unsigned SbDepth = (LOAD_LAT > 1) ? LOAD_LAT - 1 : 1;

    if (!params_ok(REG_AW, LOAD_LAT, FLUSH_CYC, CNT_W)) begin : g_param_err
        $error("hazard_ctrl: parameter out of range");
    end

    logic                          ex_load;
    logic                          sb_in_valid;
    logic [SbDepth-1:0]            sb_valid;
    logic [SbDepth-1:0][REG_AW-1:0] sb_rd;
    logic                          hit_rs1;
    logic                          hit_rs2;
    logic                          in_run;
    logic                          res_en;
    logic                          mispred;
    logic                          redirect;

    logic [0:0]     state_q, state_d;
    logic [FcW-1:0] fc_q, fc_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] miss_cnt_q, miss_cnt_d;

    if (LOAD_LAT > 1) begin : g_sb
        hazard_sb #(
            .REG_AW   (REG_AW),
            .LOAD_LAT (LOAD_LAT)
        ) u_sb (
            .clk        (clk),
            .rst        (rst),
            .en_i       (!mem_wait_i),
            .in_valid_i (sb_in_valid),
            .in_rd_i    (ex_rd_i),
            .valid_o    (sb_valid),
            .rd_o       (sb_rd)
        );
    end else begin : g_no_sb
        assign sb_valid = '0;
        assign sb_rd    = '0;
    end

    assign ex_load = ex_valid_i & ex_memread_i & ex_memtoreg_i;

    // The oldest scoreboard stage is forwardable, so it never causes a stall.
    always_comb begin
        hit_rs1 = ex_load && (ex_rd_i == id_rs1_i);
        hit_rs2 = ex_load && (ex_rd_i == id_rs2_i);
        for (int k = 0; k < int'(SbDepth); k++) begin
            if (LOAD_LAT > 1 && k != int'(SbDepth) - 1 && sb_valid[k]) begin
                if (sb_rd[k] == id_rs1_i) hit_rs1 = 1'b1;
                if (sb_rd[k] == id_rs2_i) hit_rs2 = 1'b1;
            end
        end
    end

    // In RUN a stall blocks resolution, so flush_o cannot be raised in a stall
    // cycle; gating on the state alone avoids a loop through flush_o.
    assign in_run     = (state_q == StRun);
    assign stall_o    = id_valid_i & in_run &
                        ((id_rs1_used_i & hit_rs1) | (id_rs2_used_i & hit_rs2));
    assign res_en     = id_valid_i & !stall_o & !mem_wait_i & in_run;
    assign mispred    = id_pred_i ^ id_taken_i;
    assign jr_o       = res_en & id_isjump_i;
    assign prewrong_o = res_en & id_branch_i & !id_isjump_i & mispred;
    assign precorrc_o = res_en & id_branch_i & !id_isjump_i & !mispred;
    assign redirect   = prewrong_o | jr_o;
    assign flush_o    = redirect | !in_run;
    assign sb_in_valid = ex_load & !flush_o;

    always_comb begin
        state_d     = state_q;
        fc_d        = fc_q;
        stall_cnt_d = stall_cnt_q;
        miss_cnt_d  = miss_cnt_q;
        if (!mem_wait_i) begin
            if (state_q == StRun) begin
                if (redirect && FLUSH_CYC > 1) begin
                    state_d = StFlush;
                    fc_d    = FcW'(FLUSH_CYC - 1);
                end
            end else begin
                if (fc_q == FcW'(1)) begin
                    state_d = StRun;
                    fc_d    = '0;
                end else begin
                    fc_d = fc_q - FcW'(1);
                end
            end
            if (stall_o) stall_cnt_d = CNT_W'(sat_inc(32'(stall_cnt_q), CNT_W));
            if (prewrong_o) miss_cnt_d = CNT_W'(sat_inc(32'(miss_cnt_q), CNT_W));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StRun;
            fc_q        <= '0;
            stall_cnt_q <= '0;
            miss_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            fc_q        <= fc_d;
            stall_cnt_q <= stall_cnt_d;
            miss_cnt_q  <= miss_cnt_d;
        end
    end

    assign stall_cnt_o = stall_cnt_q;
    assign miss_cnt_o  = miss_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: main instance (LOAD_LAT=2, FLUSH_CYC=3, CNT_W=4)
// plus a LOAD_LAT=3 / FLUSH_CYC=1 instance sharing the same stimulus.
module tb_hazard_ctrl;

    localparam int unsigned REG_AW = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst;
    logic              id_valid, id_rs1_used, id_rs2_used;
    logic [REG_AW-1:0] id_rs1, id_rs2;
    logic              id_branch, id_taken, id_pred, id_isjump;
    logic              ex_valid, ex_memread, ex_memtoreg;
    logic [REG_AW-1:0] ex_rd;
    logic              mem_wait;

    logic       stall, prewrong, precorrc, jr, flush;
    logic [3:0] stall_cnt, miss_cnt;
    logic        stall_b, prewrong_b, precorrc_b, jr_b, flush_b;
    logic [15:0] stall_cnt_b, miss_cnt_b;

    int errors = 0;
    int checks = 0;

    hazard_ctrl #(.REG_AW(REG_AW), .LOAD_LAT(2), .FLUSH_CYC(3), .CNT_W(4)) u_dut (
        .clk(clk), .rst(rst),
        .id_valid_i(id_valid), .id_rs1_i(id_rs1), .id_rs1_used_i(id_rs1_used),
        .id_rs2_i(id_rs2), .id_rs2_used_i(id_rs2_used),
        .id_branch_i(id_branch), .id_taken_i(id_taken), .id_pred_i(id_pred),
        .id_isjump_i(id_isjump),
        .ex_valid_i(ex_valid), .ex_memread_i(ex_memread), .ex_memtoreg_i(ex_memtoreg),
        .ex_rd_i(ex_rd), .mem_wait_i(mem_wait),
        .stall_o(stall), .prewrong_o(prewrong), .precorrc_o(precorrc), .jr_o(jr),
        .flush_o(flush), .stall_cnt_o(stall_cnt), .miss_cnt_o(miss_cnt)
    );

    hazard_ctrl #(.REG_AW(REG_AW), .LOAD_LAT(3), .FLUSH_CYC(1), .CNT_W(16)) u_dut_l3 (
        .clk(clk), .rst(rst),
        .id_valid_i(id_valid), .id_rs1_i(id_rs1), .id_rs1_used_i(id_rs1_used),
        .id_rs2_i(id_rs2), .id_rs2_used_i(id_rs2_used),
        .id_branch_i(id_branch), .id_taken_i(id_taken), .id_pred_i(id_pred),
        .id_isjump_i(id_isjump),
        .ex_valid_i(ex_valid), .ex_memread_i(ex_memread), .ex_memtoreg_i(ex_memtoreg),
        .ex_rd_i(ex_rd), .mem_wait_i(mem_wait),
        .stall_o(stall_b), .prewrong_o(prewrong_b), .precorrc_o(precorrc_b), .jr_o(jr_b),
        .flush_o(flush_b), .stall_cnt_o(stall_cnt_b), .miss_cnt_o(miss_cnt_b)
    );

    // Inputs change 1 time unit after the rising edge; checks follow 1 unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic clear_inputs();
        id_valid = 0; id_rs1 = '0; id_rs1_used = 0; id_rs2 = '0; id_rs2_used = 0;
        id_branch = 0; id_taken = 0; id_pred = 0; id_isjump = 0;
        ex_valid = 0; ex_memread = 0; ex_memtoreg = 0; ex_rd = '0; mem_wait = 0;
    endtask

    task automatic ex_load(input logic [REG_AW-1:0] rd);
        ex_valid = 1; ex_memread = 1; ex_memtoreg = 1; ex_rd = rd;
    endtask

    task automatic ex_clear();
        ex_valid = 0; ex_memread = 0; ex_memtoreg = 0; ex_rd = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1;
        tick();
        rst = 0;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 1;
        tick();
        tick();
        settle();
        checks++; if (flush !== 1'b0) begin errors++; $display("FAIL reset_flush: got %b want 0", flush); end
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b want 0", stall); end
        checks++; if (stall_cnt !== 4'd0) begin errors++; $display("FAIL reset_stall_cnt: got %0d want 0", stall_cnt); end
        checks++; if (miss_cnt !== 4'd0) begin errors++; $display("FAIL reset_miss_cnt: got %0d want 0", miss_cnt); end
        checks++; if (flush_b !== 1'b0) begin errors++; $display("FAIL reset_flush_l3: got %b want 0", flush_b); end
        rst = 0;
        tick();
    endtask

    task automatic test_load_use();
        do_reset();
        // Two back-to-back loads to r3 while the consumer of r3 waits in ID.
        id_valid = 1; id_rs1 = 4'd3; id_rs1_used = 1;
        ex_load(4'd3);
        settle();
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL load_use_c1: got %b want 1", stall); end
        checks++; if (stall_b !== 1'b1) begin errors++; $display("FAIL load_use_l3_c1: got %b want 1", stall_b); end
        tick();
        settle();
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL load_use_c2: got %b want 1", stall); end
        tick();
        ex_clear();
        settle();
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL load_use_c3: got %b want 0", stall); end
        checks++; if (stall_cnt !== 4'd2) begin errors++; $display("FAIL load_use_cnt: got %0d want 2", stall_cnt); end
        checks++; if (stall_b !== 1'b1) begin errors++; $display("FAIL load_use_l3_c3: got %b want 1", stall_b); end
        tick();
        settle();
        checks++; if (stall_b !== 1'b0) begin errors++; $display("FAIL load_use_l3_c4: got %b want 0", stall_b); end
        checks++; if (stall_cnt_b !== 16'd3) begin errors++; $display("FAIL load_use_l3_cnt: got %0d want 3", stall_cnt_b); end
        clear_inputs();
        tick();
    endtask

    task automatic test_unused_operand();
        do_reset();
        id_valid = 1; id_rs1 = 4'd5; id_rs1_used = 1; id_rs2 = 4'd3; id_rs2_used = 0;
        ex_load(4'd3);
        settle();
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL unused_rs2: got %b want 0", stall); end
        checks++; if (stall_b !== 1'b0) begin errors++; $display("FAIL unused_rs2_l3: got %b want 0", stall_b); end
        id_rs2_used = 1;
        settle();
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL used_rs2: got %b want 1", stall); end
        clear_inputs();
        tick();
    endtask

    task automatic test_mispredict();
        do_reset();
        id_valid = 1; id_branch = 1; id_pred = 1; id_taken = 0;
        settle();
        checks++; if (prewrong !== 1'b1) begin errors++; $display("FAIL mis_prewrong: got %b want 1", prewrong); end
        checks++; if (precorrc !== 1'b0) begin errors++; $display("FAIL mis_precorrc: got %b want 0", precorrc); end
        checks++; if (flush !== 1'b1) begin errors++; $display("FAIL mis_flush1: got %b want 1", flush); end
        checks++; if (prewrong_b !== 1'b1) begin errors++; $display("FAIL mis_prewrong_l3: got %b want 1", prewrong_b); end
        tick();
        settle();
        // Same branch still in ID during FLUSH must be ignored.
        checks++; if (prewrong !== 1'b0) begin errors++; $display("FAIL mis_ignore: got %b want 0", prewrong); end
        checks++; if (flush !== 1'b1) begin errors++; $display("FAIL mis_flush2: got %b want 1", flush); end
        tick();
        clear_inputs();
        settle();
        checks++; if (flush !== 1'b1) begin errors++; $display("FAIL mis_flush3: got %b want 1", flush); end
        checks++; if (flush_b !== 1'b0) begin errors++; $display("FAIL mis_flush_l3: got %b want 0", flush_b); end
        tick();
        settle();
        checks++; if (flush !== 1'b0) begin errors++; $display("FAIL mis_flush4: got %b want 0", flush); end
        checks++; if (miss_cnt !== 4'd1) begin errors++; $display("FAIL mis_cnt: got %0d want 1", miss_cnt); end
        id_valid = 1; id_branch = 1; id_pred = 1; id_taken = 1;
        settle();
        checks++; if (precorrc !== 1'b1) begin errors++; $display("FAIL cor_precorrc: got %b want 1", precorrc); end
        checks++; if (flush !== 1'b0) begin errors++; $display("FAIL cor_flush: got %b want 0", flush); end
        clear_inputs();
        tick();
    endtask

    task automatic test_jr_branch();
        do_reset();
        id_valid = 1; id_branch = 1; id_isjump = 1; id_pred = 1; id_taken = 0;
        settle();
        checks++; if (jr !== 1'b1) begin errors++; $display("FAIL jrb_jr: got %b want 1", jr); end
        checks++; if (prewrong !== 1'b0) begin errors++; $display("FAIL jrb_prewrong: got %b want 0", prewrong); end
        checks++; if (precorrc !== 1'b0) begin errors++; $display("FAIL jrb_precorrc: got %b want 0", precorrc); end
        checks++; if (flush !== 1'b1) begin errors++; $display("FAIL jrb_flush1: got %b want 1", flush); end
        tick();
        clear_inputs();
        settle();
        checks++; if (flush !== 1'b1) begin errors++; $display("FAIL jrb_flush2: got %b want 1", flush); end
        tick();
        settle();
        checks++; if (flush !== 1'b1) begin errors++; $display("FAIL jrb_flush3: got %b want 1", flush); end
        tick();
        settle();
        checks++; if (flush !== 1'b0) begin errors++; $display("FAIL jrb_flush4: got %b want 0", flush); end
        checks++; if (miss_cnt !== 4'd0) begin errors++; $display("FAIL jrb_miss: got %0d want 0", miss_cnt); end
        tick();
    endtask

    task automatic test_mem_wait();
        do_reset();
        id_valid = 1; id_branch = 1; id_pred = 1; id_taken = 0;
        tick();
        clear_inputs();
        mem_wait = 1;
        for (int i = 0; i < 4; i++) begin
            settle();
            checks++; if (flush !== 1'b1) begin errors++; $display("FAIL mw_hold%0d: got %b want 1", i, flush); end
            tick();
        end
        mem_wait = 0;
        settle();
        checks++; if (flush !== 1'b1) begin errors++; $display("FAIL mw_rel1: got %b want 1", flush); end
        tick();
        settle();
        checks++; if (flush !== 1'b1) begin errors++; $display("FAIL mw_rel2: got %b want 1", flush); end
        tick();
        settle();
        checks++; if (flush !== 1'b0) begin errors++; $display("FAIL mw_done: got %b want 0", flush); end
        // Stall is still reported while frozen, but nothing advances.
        mem_wait = 1;
        id_valid = 1; id_rs1 = 4'd3; id_rs1_used = 1;
        ex_load(4'd3);
        settle();
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL mw_stall: got %b want 1", stall); end
        tick();
        mem_wait = 0;
        ex_clear();
        settle();
        checks++; if (stall_b !== 1'b0) begin errors++; $display("FAIL mw_sb_frozen_l3: got %b want 0", stall_b); end
        checks++; if (stall_cnt !== 4'd0) begin errors++; $display("FAIL mw_stall_cnt: got %0d want 0", stall_cnt); end
        checks++; if (stall_cnt_b !== 16'd0) begin errors++; $display("FAIL mw_stall_cnt_l3: got %0d want 0", stall_cnt_b); end
        clear_inputs();
        tick();
    endtask

    task automatic test_saturation();
        do_reset();
        id_valid = 1; id_rs1 = 4'd3; id_rs1_used = 1;
        ex_load(4'd3);
        for (int i = 0; i < 20; i++) tick();
        settle();
        checks++; if (stall_cnt !== 4'd15) begin errors++; $display("FAIL sat_cnt: got %0d want 15", stall_cnt); end
        checks++; if (stall_cnt_b !== 16'd20) begin errors++; $display("FAIL sat_cnt_l3: got %0d want 20", stall_cnt_b); end
        clear_inputs();
        tick();
    endtask

    task automatic test_reset_in_flush();
        do_reset();
        id_valid = 1; id_branch = 1; id_pred = 1; id_taken = 0;
        tick();
        clear_inputs();
        ex_load(4'd5);
        settle();
        checks++; if (flush !== 1'b1) begin errors++; $display("FAIL rf_in_flush: got %b want 1", flush); end
        tick();
        rst = 1;
        tick();
        rst = 0;
        ex_clear();
        id_valid = 1; id_rs1 = 4'd5; id_rs1_used = 1;
        settle();
        checks++; if (flush !== 1'b0) begin errors++; $display("FAIL rf_flush: got %b want 0", flush); end
        checks++; if (miss_cnt !== 4'd0) begin errors++; $display("FAIL rf_miss: got %0d want 0", miss_cnt); end
        checks++; if (miss_cnt_b !== 16'd0) begin errors++; $display("FAIL rf_miss_l3: got %0d want 0", miss_cnt_b); end
        checks++; if (stall_b !== 1'b0) begin errors++; $display("FAIL rf_sb_empty_l3: got %b want 0", stall_b); end
        clear_inputs();
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got no finish want finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1;
        clear_inputs();
        test_reset();
        test_load_use();
        test_unused_operand();
        test_mispredict();
        test_jr_branch();
        test_mem_wait();
        test_saturation();
        test_reset_in_flush();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
